game_flow_controller: RTL
=========================

Name: game_flow_controller

Overview:
Frame-rate game sequencer sitting between the CollisionDetector/InputController and the entity datapath (PlayerLogic, DragonBody, PPU heart entity). It samples collision flags and the attack button once per frame, runs the title/play/hit/game-over state machine, and tracks lives, score and dragon length. It issues one-cycle length_update commands to DragonBody and a game_reset pulse to re-initialise entities.

Parameters:
START_LIVES, 3, lives loaded at reset and on game start (1..3)
INVULN_FRAMES, 60, frames of invulnerability after a player hit (1..255)
GROW_INTERVAL, 600, PLAY/HIT frames between automatic dragon growth (1..1023)
START_LENGTH, 1, dragon length loaded on game start (1..7)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
frame_end  in  1  one-cycle pulse per frame; sole update strobe
attack  in  1  attack button level (from input_data)
player_dragon_collision  in  1  collision flag, valid when frame_end=1
sword_dragon_collision  in  1  collision flag, valid when frame_end=1
sheep_dragon_collision  in  1  collision flag, valid when frame_end=1
game_state  out  2  00 IDLE, 01 PLAY, 10 HIT, 11 OVER
player_lives  out  2  remaining lives (drives heart entity)
score  out  8  sword hits, saturating
dragon_length  out  3  tracked dragon length, 1..7
length_update  out  2  00 none, 01 grow, 10 shrink; one-cycle pulse
game_reset  out  1  one-cycle pulse on game start
player_visible  out  1  player sprite enable (blinks in HIT)
game_won  out  1  set when dragon shrunk below length 1

Behaviour:
- Reset (rst_n=0 at clk edge, any state): state IDLE, player_lives=START_LIVES, score=0, dragon_length=START_LENGTH, length_update=00, game_reset=0, player_visible=1, game_won=0, counters 0, attack_prev=0.
- All state/counter updates happen only on clk edges where frame_end=1; between frames, outputs hold, except pulses.
- Attack edge: atk_rise = attack & ~attack_prev, where attack_prev is captured only at frame_end.
- length_update and game_reset are registered: asserted the cycle after the frame_end cycle, exactly 1 cycle wide, 00/0 otherwise.
- IDLE: collisions ignored. On atk_rise -> PLAY; game_reset pulse; reload lives, score=0, dragon_length=START_LENGTH, game_won=0, grow counter=0.
- PLAY, per frame, evaluated together:
  - player collision: lives-1. If lives was 1 -> OVER, lives=0. Else -> HIT, invuln counter=INVULN_FRAMES.
  - sword collision: score+1, saturating at 255; shrink request.
  - sheep collision or grow counter reaching GROW_INTERVAL-1 (counter then wraps to 0): grow request.
  - Grow and shrink in the same frame cancel: length_update=00, length unchanged.
  - Grow at length 7: no command. Shrink at length 1: no command; game_won=1 -> OVER. Win takes priority over a simultaneous player hit; lives are not decremented.
  - Otherwise the command is issued and dragon_length is adjusted ±1 on the same edge as the pulse.
- HIT: player collisions ignored; sword, sheep and grow logic as in PLAY. Counter decrements each frame; a frame at counter=1 -> PLAY (counter 0). player_visible = invuln counter bit 3; it is 1 in every other state.
- OVER: all collisions ignored; outputs frozen. On atk_rise -> IDLE (no game_reset). A button held across the state change does not trigger, because the edge is required.
- Grow counter runs only in PLAY/HIT and is 10 bits wide.

Test Plan:
- Reset with attack high, then release; press for 1 frame -> IDLE to PLAY on that frame_end, game_reset=1 for exactly one cycle, lives=3, score=0, length=1.
- PLAY, player collision on one frame -> lives=2, state HIT, player_visible toggling every 8 frames; collision during HIT ignored; after 60 frames state=PLAY.
- Three player hits, each outside invulnerability -> lives 3/2/1/0, final state OVER; attack held from before -> stays OVER; release, press -> IDLE.
- Sheep collision 6 times -> length_update=01 six times, length=7; 7th sheep -> length_update=00, length stays 7; sword+sheep same frame -> 00, score+1, length unchanged.
- Length 1, sword collision together with player collision -> game_won=1, state OVER, lives unchanged, score+1, length_update=00.
- GROW_INTERVAL=4, no collisions -> length_update=01 every 4th frame; rst_n=0 mid-HIT -> next edge IDLE, all outputs at reset values.

Source files
------------

// File: rtl/game_flow_controller_if.sv
// Bundle between the frame-rate game sequencer and its collision/input sources and entity sinks.
// The controller takes the slave view.
interface game_flow_controller_if;
    logic       frame_end;
    logic       attack;
    logic       player_dragon_collision;
    logic       sword_dragon_collision;
    logic       sheep_dragon_collision;
    logic [1:0] game_state;
    logic [1:0] player_lives;
    logic [7:0] score;
    logic [2:0] dragon_length;
    logic [1:0] length_update;
    logic       game_reset;
    logic       player_visible;
    logic       game_won;

    modport master (
        output frame_end, attack, player_dragon_collision, sword_dragon_collision,
               sheep_dragon_collision,
        input  game_state, player_lives, score, dragon_length, length_update, game_reset,
               player_visible, game_won
    );

    modport slave (
        input  frame_end, attack, player_dragon_collision, sword_dragon_collision,
               sheep_dragon_collision,
        output game_state, player_lives, score, dragon_length, length_update, game_reset,
               player_visible, game_won
    );
endinterface

// File: rtl/game_flow_controller.sv
// Frame-rate game sequencer: title/play/hit/game-over flow, lives, score and dragon length.
// All state advances only on frame_end; length_update and game_reset are one-cycle pulses.
module game_flow_controller #(
    parameter int unsigned START_LIVES   = 3,
    parameter int unsigned INVULN_FRAMES = 60,
    parameter int unsigned GROW_INTERVAL = 600,
    parameter int unsigned START_LENGTH  = 1
) (
    input logic                   clk,
    input logic                   rst_n,
    game_flow_controller_if.slave bus
);

    localparam logic [1:0] StIdle = 2'b00;
    localparam logic [1:0] StPlay = 2'b01;
    localparam logic [1:0] StHit  = 2'b10;
    localparam logic [1:0] StOver = 2'b11;

    localparam logic [1:0] UpdNone   = 2'b00;
    localparam logic [1:0] UpdGrow   = 2'b01;
    localparam logic [1:0] UpdShrink = 2'b10;

    localparam logic [1:0] LivesInit  = 2'(START_LIVES);
    localparam logic [2:0] LengthInit = 3'(START_LENGTH);
    localparam logic [7:0] InvulnInit = 8'(INVULN_FRAMES);
    localparam logic [9:0] GrowLast   = 10'(GROW_INTERVAL - 1);

    logic [1:0] state_q, state_d;
    logic [1:0] lives_q, lives_d;
    logic [7:0] score_q, score_d;
    logic [2:0] length_q, length_d;
    logic       won_q, won_d;
    logic [7:0] invuln_q, invuln_d;
    logic [9:0] grow_cnt_q, grow_cnt_d;
    logic       attack_prev_q, attack_prev_d;
    logic [1:0] length_update_q, length_update_d;
    logic       game_reset_q, game_reset_d;

    logic atk_rise;
    logic active;
    logic grow_req;
    logic shrink_req;
    logic win;

    always_comb begin
        state_d         = state_q;
        lives_d         = lives_q;
        score_d         = score_q;
        length_d        = length_q;
        won_d           = won_q;
        invuln_d        = invuln_q;
        grow_cnt_d      = grow_cnt_q;
        attack_prev_d   = attack_prev_q;
        length_update_d = UpdNone;
        game_reset_d    = 1'b0;
        atk_rise        = bus.attack & ~attack_prev_q;
        active          = (state_q == StPlay) || (state_q == StHit);
        grow_req        = 1'b0;
        shrink_req      = 1'b0;
        win             = 1'b0;

        if (bus.frame_end) begin
            attack_prev_d = bus.attack;

            // Dragon growth/shrink bookkeeping shared by PLAY and HIT.
            if (active) begin
                if (grow_cnt_q == GrowLast) begin
                    grow_req   = 1'b1;
                    grow_cnt_d = '0;
                end else begin
                    grow_cnt_d = grow_cnt_q + 10'd1;
                end
                if (bus.sheep_dragon_collision) begin
                    grow_req = 1'b1;
                end
                if (bus.sword_dragon_collision) begin
                    shrink_req = 1'b1;
                    if (score_q != 8'hff) begin
                        score_d = score_q + 8'd1;
                    end
                end
                if (grow_req && !shrink_req && (length_q != 3'd7)) begin
                    length_update_d = UpdGrow;
                    length_d        = length_q + 3'd1;
                end else if (shrink_req && !grow_req) begin
                    if (length_q == 3'd1) begin
                        win = 1'b1;
                    end else begin
                        length_update_d = UpdShrink;
                        length_d        = length_q - 3'd1;
                    end
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (atk_rise) begin
                        state_d      = StPlay;
                        game_reset_d = 1'b1;
                        lives_d      = LivesInit;
                        score_d      = '0;
                        length_d     = LengthInit;
                        won_d        = 1'b0;
                        grow_cnt_d   = '0;
                    end
                end
                StPlay: begin
                    // A win outranks a simultaneous player hit; lives stay intact.
                    if (win) begin
                        state_d = StOver;
                        won_d   = 1'b1;
                    end else if (bus.player_dragon_collision) begin
                        if (lives_q <= 2'd1) begin
                            state_d = StOver;
                            lives_d = 2'd0;
                        end else begin
                            state_d  = StHit;
                            lives_d  = lives_q - 2'd1;
                            invuln_d = InvulnInit;
                        end
                    end
                end
                StHit: begin
                    if (win) begin
                        state_d  = StOver;
                        won_d    = 1'b1;
                        invuln_d = '0;
                    end else if (invuln_q <= 8'd1) begin
                        state_d  = StPlay;
                        invuln_d = '0;
                    end else begin
                        invuln_d = invuln_q - 8'd1;
                    end
                end
                StOver: begin
                    if (atk_rise) begin
                        state_d = StIdle;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            lives_q         <= LivesInit;
            score_q         <= '0;
            length_q        <= LengthInit;
            won_q           <= 1'b0;
            invuln_q        <= '0;
            grow_cnt_q      <= '0;
            attack_prev_q   <= 1'b0;
            length_update_q <= UpdNone;
            game_reset_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            lives_q         <= lives_d;
            score_q         <= score_d;
            length_q        <= length_d;
            won_q           <= won_d;
            invuln_q        <= invuln_d;
            grow_cnt_q      <= grow_cnt_d;
            attack_prev_q   <= attack_prev_d;
            length_update_q <= length_update_d;
            game_reset_q    <= game_reset_d;
        end
    end

    assign bus.game_state     = state_q;
    assign bus.player_lives   = lives_q;
    assign bus.score          = score_q;
    assign bus.dragon_length  = length_q;
    assign bus.length_update  = length_update_q;
    assign bus.game_reset     = game_reset_q;
    // Blink the player sprite from the invulnerability countdown while hit.
    assign bus.player_visible = (state_q == StHit) ? invuln_q[3] : 1'b1;
    assign bus.game_won       = won_q;

endmodule
